io_bridge: RTL and testbench

- Sits between the hmc-6502 core bus and the rest of the chip.
- Each cycle it decodes the core's address and read_en. It steers memory accesses to the external memory port and returns read data to the core's data_in.
- It implements a small memory-mapped I/O page: a transmit FIFO with a valid/ready drain port, a status register, and an 8-bit down-counting timer.

---
 rtl/io_bridge.sv | 165 ++++++++++++++++
 tb/tb_io_bridge.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/io_bridge.sv
// Core-side bus bridge for the hmc-6502: steers memory traffic to the external port and
// serves a 4-byte I/O page holding a transmit FIFO, a status register and a down-counting timer.
module io_bridge #(
    parameter logic [15:0] IO_BASE    = 16'hFF00,
    parameter int          FIFO_DEPTH = 4,
    parameter int          PTR_W      = 2
) (
    input  logic        ph0,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic [7:0]  data_out,
    input  logic        read_en,
    output logic [7:0]  data_in,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        timer_irq
);

    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_DEPTH = (PTR_W + 1)'(FIFO_DEPTH);

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             expired_q, expired_d;
    logic             enable_q, enable_d;
    logic [7:0]       timer_q, timer_d;

    logic       io_sel_s, wr_s, full_s, empty_s;
    logic       push_s, pop_s, do_push_s, status_wr_s, timer_wr_s, tctrl_wr_s, dec_s;
    logic [1:0] offset_s;
    logic [7:0] io_rdata_s;

    assign io_sel_s    = (address[15:2] == IO_BASE[15:2]);
    assign offset_s    = address[1:0];
    assign wr_s        = ~read_en & io_sel_s;
    assign full_s      = (count_q == CNT_DEPTH);
    assign empty_s     = (count_q == '0);
    assign push_s      = wr_s & (offset_s == 2'd0);
    assign pop_s       = tx_valid & tx_ready;
    // A push into a full FIFO still lands when the head leaves in the same cycle.
    assign do_push_s   = push_s & (~full_s | pop_s);
    assign status_wr_s = wr_s & (offset_s == 2'd1);
    assign timer_wr_s  = wr_s & (offset_s == 2'd2);
    assign tctrl_wr_s  = wr_s & (offset_s == 2'd3);
    assign dec_s       = enable_q & (timer_q != 8'd0) & ~timer_wr_s;

    assign mem_addr  = address;
    assign mem_wdata = data_out;
    assign mem_we    = ~read_en & ~io_sel_s & ~reset;
    assign tx_valid  = ~empty_s;
    assign tx_data   = mem_q[rd_ptr_q];
    assign timer_irq = expired_q;

    // I/O page read mux and core read-data steering
    always_comb begin
        io_rdata_s = 8'h00;
        case (offset_s)
            2'd0:    io_rdata_s = 8'h00;
            2'd1:    io_rdata_s = {4'b0000, overflow_q, expired_q, empty_s, full_s};
            2'd2:    io_rdata_s = timer_q;
            2'd3:    io_rdata_s = {7'b0000000, enable_q};
            default: io_rdata_s = 8'h00;
        endcase
        if (io_sel_s) begin
            data_in = io_rdata_s;
        end else begin
            data_in = mem_rdata;
        end
    end

    // Next-state logic for FIFO bookkeeping, status flags and timer
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        expired_d  = expired_q;
        enable_d   = enable_q;
        timer_d    = timer_q;

        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        if (push_s & full_s & ~pop_s) begin
            overflow_d = 1'b1;
        end else if (status_wr_s & data_out[3]) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end

        if (timer_wr_s) begin
            timer_d = data_out;
        end else if (dec_s) begin
            timer_d = timer_q - 8'd1;
        end else begin
            timer_d = timer_q;
        end

        // Expiry by decrement beats a simultaneous software clear.
        if (dec_s & (timer_q == 8'd1)) begin
            expired_d = 1'b1;
        end else if (status_wr_s & data_out[2]) begin
            expired_d = 1'b0;
        end else begin
            expired_d = expired_q;
        end

        if (tctrl_wr_s) begin
            enable_d = data_out[0];
        end else begin
            enable_d = enable_q;
        end
    end

    // Control state registers with synchronous reset
    always_ff @(posedge ph0) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            expired_q  <= 1'b0;
            enable_q   <= 1'b0;
            timer_q    <= 8'h00;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            expired_q  <= expired_d;
            enable_q   <= enable_d;
            timer_q    <= timer_d;
        end
    end

    // FIFO storage is deliberately left out of reset
    always_ff @(posedge ph0) begin
        if (do_push_s & ~reset) begin
            mem_q[wr_ptr_q] <= data_out;
        end
    end

endmodule

// File: tb/tb_io_bridge.sv
// Scoreboard bench for io_bridge: transmitted bytes are checked by a monitor against a queue,
// register reads and decode outputs are checked with directed expected values.
module tb_io_bridge;

    logic        ph0 = 1'b0;
    logic        reset;
    logic [15:0] address;
    logic [7:0]  data_out;
    logic        read_en;
    logic [7:0]  data_in;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        timer_irq;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_q [$];
    logic [7:0] mon_exp;

    io_bridge #(.IO_BASE(16'hFF00), .FIFO_DEPTH(4), .PTR_W(2)) dut (
        .ph0(ph0), .reset(reset), .address(address), .data_out(data_out),
        .read_en(read_en), .data_in(data_in), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .timer_irq(timer_irq)
    );

    always #5 ph0 = ~ph0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge ph0);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        address  = a;
        data_out = d;
        read_en  = 1'b0;
        step();
        read_en  = 1'b1;
        address  = 16'h0000;
    endtask

    task automatic rd(input logic [15:0] a);
        address = a;
        read_en = 1'b1;
        #1;
    endtask

    task automatic push_exp(input logic [15:0] a, input logic [7:0] d);
        exp_q.push_back(d);
        wr(a, d);
    endtask

    // Monitor: every handshake seen between edges must match the scoreboard head
    always @(negedge ph0) begin
        if (!reset && tx_valid === 1'b1 && tx_ready === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL tx_unexpected: got %h expected none", tx_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (tx_data !== mon_exp) begin
                    n_err++;
                    $display("FAIL tx_data: got %h expected %h", tx_data, mon_exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; address = 16'h0000; data_out = 8'h00; read_en = 1'b1;
        mem_rdata = 8'h00; tx_ready = 1'b0;
        step(); step();
        reset = 1'b0;

        // Reset state
        rd(16'hFF01);
        chk("rst_status", {8'h00, data_in}, 16'h0002);
        chk("rst_tx_valid", {15'd0, tx_valid}, 16'h0000);
        chk("rst_irq", {15'd0, timer_irq}, 16'h0000);
        chk("rst_mem_we", {15'd0, mem_we}, 16'h0000);

        // Two bytes, then drain
        push_exp(16'hFF00, 8'h41);
        push_exp(16'hFF00, 8'h42);
        #1;
        chk("two_valid", {15'd0, tx_valid}, 16'h0001);
        chk("two_head", {8'h00, tx_data}, 16'h0041);
        rd(16'hFF00);
        chk("txdata_read", {8'h00, data_in}, 16'h0000);
        tx_ready = 1'b1;
        step(); step();
        tx_ready = 1'b0;
        #1;
        chk("two_drained", {15'd0, tx_valid}, 16'h0000);

        // Overflow: five pushes into a 4-deep FIFO, the 5th is dropped
        push_exp(16'hFF00, 8'h11);
        push_exp(16'hFF00, 8'h12);
        push_exp(16'hFF00, 8'h13);
        push_exp(16'hFF00, 8'h14);
        wr(16'hFF00, 8'h15);
        rd(16'hFF01);
        chk("ovf_status", {8'h00, data_in}, 16'h0009);
        wr(16'hFF01, 8'h08);
        rd(16'hFF01);
        chk("ovf_cleared", {8'h00, data_in}, 16'h0001);
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        tx_ready = 1'b0;
        #1;
        chk("ovf_drained", {15'd0, tx_valid}, 16'h0000);

        // Full FIFO with simultaneous push and pop
        push_exp(16'hFF00, 8'h21);
        push_exp(16'hFF00, 8'h22);
        push_exp(16'hFF00, 8'h23);
        push_exp(16'hFF00, 8'h24);
        tx_ready = 1'b1;
        push_exp(16'hFF00, 8'h25);
        tx_ready = 1'b0;
        rd(16'hFF01);
        chk("full_pp_status", {8'h00, data_in}, 16'h0001);
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        tx_ready = 1'b0;
        #1;
        chk("full_pp_drained", {15'd0, tx_valid}, 16'h0000);

        // Single entry with simultaneous push and pop
        push_exp(16'hFF00, 8'h31);
        tx_ready = 1'b1;
        push_exp(16'hFF00, 8'h32);
        tx_ready = 1'b0;
        rd(16'hFF01);
        chk("one_pp_status", {8'h00, data_in}, 16'h0000);
        chk("one_pp_head", {8'h00, tx_data}, 16'h0032);
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        #1;
        chk("one_pp_drained", {15'd0, tx_valid}, 16'h0000);

        // Timer count-down and sticky expiry
        wr(16'hFF02, 8'h03);
        wr(16'hFF03, 8'h01);
        rd(16'hFF02);
        chk("tmr_loaded", {8'h00, data_in}, 16'h0003);
        step(); #1;
        chk("tmr_2", {8'h00, data_in}, 16'h0002);
        step(); #1;
        chk("tmr_1", {8'h00, data_in}, 16'h0001);
        chk("tmr_irq_low", {15'd0, timer_irq}, 16'h0000);
        step(); #1;
        chk("tmr_0", {8'h00, data_in}, 16'h0000);
        chk("tmr_irq_high", {15'd0, timer_irq}, 16'h0001);
        step(); #1;
        chk("tmr_hold0", {8'h00, data_in}, 16'h0000);
        rd(16'hFF01);
        chk("tmr_status", {8'h00, data_in}, 16'h0006);
        wr(16'hFF01, 8'h04);
        rd(16'hFF01);
        chk("tmr_cleared", {8'h00, data_in}, 16'h0002);
        chk("tmr_irq_cleared", {15'd0, timer_irq}, 16'h0000);
        rd(16'hFF03);
        chk("tctrl_read", {8'h00, data_in}, 16'h0001);
        wr(16'hFF02, 8'h00);
        step();
        rd(16'hFF01);
        chk("load0_no_expire", {8'h00, data_in}, 16'h0002);

        // Memory decode
        address = 16'h0200; data_out = 8'h77; read_en = 1'b0;
        #1;
        chk("mem_we_hi", {15'd0, mem_we}, 16'h0001);
        chk("mem_addr", mem_addr, 16'h0200);
        chk("mem_wdata", {8'h00, mem_wdata}, 16'h0077);
        step();
        address = 16'hFF00; data_out = 8'h99;
        #1;
        chk("mem_we_io", {15'd0, mem_we}, 16'h0000);
        exp_q.push_back(8'h99);
        step();
        read_en = 1'b1; address = 16'h1234; mem_rdata = 8'h5A;
        #1;
        chk("mem_rdata", {8'h00, data_in}, 16'h005A);
        push_exp(16'hFF00, 8'h98);

        // Reset in the middle of a drain
        tx_ready = 1'b1;
        step();
        reset = 1'b1;
        address = 16'h0200; read_en = 1'b0;
        #1;
        chk("rst_mem_we_gated", {15'd0, mem_we}, 16'h0000);
        step();
        exp_q.delete();
        chk("rst_mid_valid", {15'd0, tx_valid}, 16'h0000);
        reset = 1'b0; tx_ready = 1'b0;
        rd(16'hFF03);
        chk("rst_tctrl", {8'h00, data_in}, 16'h0000);
        rd(16'hFF01);
        chk("rst_status2", {8'h00, data_in}, 16'h0002);
        chk("rst_irq2", {15'd0, timer_irq}, 16'h0000);

        step();
        chk("scoreboard_empty", 16'(exp_q.size()), 16'h0000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
